spi_slave_core: RTL and testbench

//  Parametrised SPI slave front end: synchronises sclk/ss/mosi into clk, supports all four

---
 rtl/spi_slave_core_pkg.sv | 30 +++
 rtl/spi_slave_core_if.sv | 53 +++++
 rtl/spi_slave_core_sync.sv | 25 ++
 rtl/spi_slave_core.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI slave core: FSM states, SPI mode
// encodings ({cpol, cpha}) and the default word width.
package spi_slave_core_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic {
    SpiStIdle   = 1'b0,
    SpiStActive = 1'b1
  } spi_state_e;

  // Mode is {cpol, cpha}
  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t SpiMode0 = 2'b00;
  localparam spi_mode_t SpiMode1 = 2'b01;
  localparam spi_mode_t SpiMode2 = 2'b10;
  localparam spi_mode_t SpiMode3 = 2'b11;

  // Modes 0 and 3 sample MOSI on the rising sclk edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(spi_mode_t mode);
    logic rise;
    unique case (mode)
      SpiMode0, SpiMode3: rise = 1'b1;
      SpiMode1, SpiMode2: rise = 1'b0;
    endcase
    return rise;
  endfunction

endpackage

// File: rtl/spi_slave_core_if.sv
// Pin-side and parallel-side signal bundle of the SPI slave core.
// SPI_SLAVE_LSB_FIRST_EN adds the lsb_first bit-order select.
interface spi_slave_core_if
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
);

  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              ss_neg_edge;
  logic              ss_pos_edge;
  logic              frame_err;
  logic              tx_underrun;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic              lsb_first;

  modport slave (
    input  sclk, ss, mosi, cpol, cpha, tx_data, tx_valid, lsb_first,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, ss_neg_edge, ss_pos_edge,
           frame_err, tx_underrun
  );

  modport master (
    output sclk, ss, mosi, cpol, cpha, tx_data, tx_valid, lsb_first,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, ss_neg_edge, ss_pos_edge,
           frame_err, tx_underrun
  );
`else
  modport slave (
    input  sclk, ss, mosi, cpol, cpha, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, ss_neg_edge, ss_pos_edge,
           frame_err, tx_underrun
  );

  modport master (
    output sclk, ss, mosi, cpol, cpha, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, ss_neg_edge, ss_pos_edge,
           frame_err, tx_underrun
  );
`endif

endinterface

// File: rtl/spi_slave_core_sync.sv
// Multi-flop synchroniser bringing one asynchronous SPI pin into the clk domain.
module spi_slave_core_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  // Shift the pin value through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave front end: synchronised pins, all four CPOL/CPHA modes, back-to-back words
// per frame, valid/ready TX holding register and RX strobe.
// Optional feature macro: SPI_SLAVE_LSB_FIRST_EN (adds lsb_first bit-order select).
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned       DATA_W      = DefaultDataW,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}}
) (
  input logic             clk,
  input logic             rst,
  spi_slave_core_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_s, ss_s, mosi_s, sclk_q;

  spi_slave_core_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(bus.sclk), .q_o(sclk_s)
  );
  spi_slave_core_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d_i(bus.ss), .q_o(ss_s)
  );
  spi_slave_core_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(bus.mosi), .q_o(mosi_s)
  );

  // Delayed synchronised sclk for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sclk_q <= 1'b0;
    else      sclk_q <= sclk_s;
  end

  // ---------------------------------------------------------------- FSM
  spi_state_e state_q, state_d;
  logic enter, leave, run, active;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SpiStIdle;
    else      state_q <= state_d;
  end

  // Next state: a frame lasts while synchronised ss stays low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SpiStIdle:   if (!ss_s) state_d = SpiStActive;
      SpiStActive: if (ss_s)  state_d = SpiStIdle;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    enter  = 1'b0;
    leave  = 1'b0;
    run    = 1'b0;
    active = 1'b0;
    unique case (state_q)
      SpiStIdle:   enter = ~ss_s;
      SpiStActive: begin
        active = 1'b1;
        leave  = ss_s;
        run    = ~ss_s;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d, rx_data_q;
  logic              hold_full_q, hold_full_d;
  logic              first_q, first_d, last_q, last_d;
  logic              underrun_q, underrun_d;
  logic              word_done_q, rx_valid_q, ss_neg_q, ss_pos_q, frame_err_q, ready_en_q;
  logic              lsb_sel;
  logic              sclk_rise, sclk_fall, on_rise, samp, shft, word_end;
  logic              load_word, use_hold, accept, tx_ready;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_q;

  // Bit order is fixed for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       lsb_q <= 1'b0;
    else if (enter) lsb_q <= bus.lsb_first;
  end
  assign lsb_sel = lsb_q;
`else
  assign lsb_sel = 1'b0;
`endif

  // Edge classification and word-boundary events.
  always_comb begin
    sclk_rise = sclk_s & ~sclk_q;
    sclk_fall = ~sclk_s & sclk_q;
    on_rise   = sample_on_rise({cpol_q, cpha_q});
    samp      = run & (on_rise ? sclk_rise : sclk_fall);
    shft      = run & (on_rise ? sclk_fall : sclk_rise);
    word_end  = samp & (bit_cnt_q == LastBit);
    load_word = enter | (shft & last_q);
    use_hold  = load_word & hold_full_q;
    tx_ready  = ready_en_q & ~hold_full_q;
    accept    = bus.tx_valid & tx_ready;
  end

  // Next-state for shift registers, counters, holding register and sticky flag.
  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    first_d     = first_q;
    last_d      = last_q;
    underrun_d  = underrun_q;
    hold_d      = hold_q;
    hold_full_d = accept | (hold_full_q & ~use_hold);
    if (accept) hold_d = bus.tx_data;

    if (enter) begin
      cpol_d     = bus.cpol;
      cpha_d     = bus.cpha;
      bit_cnt_d  = '0;
      first_d    = bus.cpha; // cpha=1: first leading edge only confirms the preloaded MSB
      last_d     = 1'b0;
      underrun_d = 1'b0;
    end

    if (samp) begin
      rx_sh_d   = lsb_sel ? {mosi_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_s};
      bit_cnt_d = word_end ? '0 : bit_cnt_q + 1'b1;
      if (word_end) last_d = 1'b1;
    end

    if (shft) begin
      if (last_q)       last_d  = 1'b0;
      else if (first_q) first_d = 1'b0;
      else              tx_sh_d = lsb_sel ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end

    if (load_word) begin
      tx_sh_d = hold_full_q ? hold_q : TX_IDLE;
      if (!hold_full_q) underrun_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= TX_IDLE;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ss_neg_q    <= 1'b0;
      ss_pos_q    <= 1'b0;
      frame_err_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      first_q     <= first_d;
      last_q      <= last_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      word_done_q <= word_end;
      if (word_done_q) rx_data_q <= rx_sh_q;
      rx_valid_q  <= word_done_q;
      ss_neg_q    <= enter;
      ss_pos_q    <= leave;
      frame_err_q <= leave & (bit_cnt_q != '0);
      ready_en_q  <= 1'b1; // keeps tx_ready low while reset is asserted
    end
  end

  assign bus.miso        = lsb_sel ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign bus.miso_oe     = active;
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.ss_neg_edge = ss_neg_q;
  assign bus.ss_pos_edge = ss_pos_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: bench-driven SPI master, host TX pusher and
// a word-level reference model of what the slave must receive and return.
module tb_spi_slave_core;
  import spi_slave_core_pkg::*;

  localparam int        DW     = 8;
  localparam int        NS     = 2;
  localparam logic [7:0] IDLE_W = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_core_if #(.DATA_W(DW)) bus ();

  spi_slave_core #(.DATA_W(DW), .SYNC_STAGES(NS), .TX_IDLE(IDLE_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] last_rx = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_first_ur = 1'b0;
  int         last_samp_cyc = 0;
  int         neg_cnt = 0;
  int         pos_cnt = 0;
  logic [7:0] send_w[$];
  logic [7:0] push_w[$];
  logic [7:0] rdw[0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every cycle.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_rx.delete();
        last_rx = 8'h00;
        chk("reset_outputs",
            {bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.ss_neg_edge,
             bus.ss_pos_edge, bus.frame_err, bus.tx_underrun, bus.rx_data},
            {1'b1, 7'b0, 8'h00});
      end else begin
        if (bus.rx_valid) begin
          if (exp_rx.size() == 0) begin
            chk("rx_unexpected", bus.rx_valid, 0);
          end else begin
            e = exp_rx.pop_front();
            chk("rx_data", bus.rx_data, e);
            chk("rx_latency", cyc - last_samp_cyc, NS + 2);
            last_rx = e;
          end
        end else begin
          chk("rx_hold", bus.rx_data, last_rx);
        end
        if (bus.ss_pos_edge) begin
          pos_cnt++;
          chk("frame_err", bus.frame_err, exp_ferr);
        end else if (bus.frame_err) begin
          chk("frame_err_stray", bus.frame_err, 0);
        end
        if (bus.ss_neg_edge) begin
          neg_cnt++;
          chk("underrun_at_start", bus.tx_underrun, exp_first_ur);
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] w);
    int t = 0;
    while (!bus.tx_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_ready) chk("tx_ready_timeout", bus.tx_ready, 1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // One SPI frame as master. abort_bit >= 0 asserts reset before that bit and returns.
  task automatic run_frame(input spi_mode_t mode, input int nbits, input int hc,
                           input int avail, input int abort_bit);
    logic       cpol, cpha, bitv;
    logic [7:0] w;
    logic [7:0] ld[$];
    int         full, loads, n0, p0;
    cpol  = mode[1];
    cpha  = mode[0];
    full  = nbits / DW;
    // One load at frame start, one per completed word that is followed by a shift edge.
    loads = 1 + full - ((cpha && (nbits % DW == 0)) ? 1 : 0);
    for (int j = 0; j < loads; j++) ld.push_back(j < avail ? push_w[j] : IDLE_W);
    for (int j = 0; j < 4; j++) rdw[j] = 8'h00;
    exp_ferr     = (nbits % DW) != 0;
    exp_first_ur = (avail == 0);
    n0 = neg_cnt;
    p0 = pos_cnt;
    if (avail > 0) push_word(push_w[0]);
    bus.cpol = cpol;
    bus.cpha = cpha;
    bus.sclk = cpol;
    w = send_w[0];
    bus.mosi = w[DW-1];
    repeat (4) @(negedge clk);
    bus.ss = 1'b0;
    fork
      begin
        for (int k = 1; k < avail; k++) push_word(push_w[k]);
      end
      begin
        repeat (6) @(negedge clk);
        chk("miso_oe_active", bus.miso_oe, 1);
        bus.cpol = ~cpol; // must be ignored mid-frame
        bus.cpha = ~cpha;
        for (int b = 0; b < nbits; b++) begin
          if (b == abort_bit) begin
            #2 rst = 1'b0;
            break;
          end
          w    = send_w[b / DW];
          bitv = w[DW-1 - (b % DW)];
          if (!cpha) begin
            bus.mosi = bitv;
            repeat (hc) @(negedge clk);
          end else begin
            repeat (hc) @(negedge clk);
            bus.sclk = ~bus.sclk;
            bus.mosi = bitv;
            repeat (hc) @(negedge clk);
          end
          if (b / DW < 4) rdw[b / DW] = {rdw[b / DW][6:0], bus.miso};
          if (b % DW == DW - 1) begin
            exp_rx.push_back(w);
            last_samp_cyc = cyc;
          end
          bus.sclk = ~bus.sclk;
          if (!cpha) begin
            repeat (hc) @(negedge clk);
            bus.sclk = ~bus.sclk;
          end
        end
      end
    join
    if (abort_bit >= 0) return;
    repeat (hc) @(negedge clk);
    bus.ss = 1'b1;
    repeat (12) @(negedge clk);
    chk("rx_all_seen", exp_rx.size(), 0);
    for (int j = 0; j < full && j < 4; j++) chk("miso_word", rdw[j], ld[j]);
    chk("underrun_sticky", bus.tx_underrun, avail < loads);
    chk("ss_neg_count", neg_cnt - n0, 1);
    chk("ss_pos_count", pos_cnt - p0, 1);
    chk("miso_oe_idle", bus.miso_oe, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_mode_t m;
    int        nw, nb, loads, av;
    bus.sclk     = 1'b0;
    bus.ss       = 1'b1;
    bus.mosi     = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_tx_ready", bus.tx_ready, 1);
    chk("post_reset_miso_oe", bus.miso_oe, 0);

    // Mode 0 single word.
    send_w = '{8'hA5};
    push_w = '{8'h3C};
    run_frame(SpiMode0, 8, 8, 1, -1);
    chk("t1_master_read", rdw[0], 8'h3C);
    chk("t1_rx_data", bus.rx_data, 8'hA5);

    // Modes 1..3.
    for (int i = 1; i < 4; i++) begin
      m = spi_mode_t'(i);
      send_w = '{8'h81};
      push_w = '{8'h7E};
      run_frame(m, 8, 7, 1, -1);
      chk("t2_master_read", rdw[0], 8'h7E);
      chk("t2_rx_data", bus.rx_data, 8'h81);
    end

    // Three back-to-back words with refill.
    send_w = '{8'h11, 8'h22, 8'h33};
    push_w = '{8'hC1, 8'hC2, 8'hC3};
    run_frame(SpiMode0, 24, 6, 3, -1);
    chk("t3_read0", rdw[0], 8'hC1);
    chk("t3_read1", rdw[1], 8'hC2);
    chk("t3_read2", rdw[2], 8'hC3);
    chk("t3_rx_data", bus.rx_data, 8'h33);

    // Underrun, then cleared by the next frame start.
    send_w = '{8'h42};
    push_w.delete();
    run_frame(SpiMode0, 8, 6, 0, -1);
    chk("t4_master_read_idle", rdw[0], 8'hFF);
    chk("t4_underrun_set", bus.tx_underrun, 1);
    send_w = '{8'h99};
    push_w = '{8'h66};
    run_frame(SpiMode3, 8, 6, 1, -1);
    chk("t4_underrun_clear", bus.tx_underrun, 0);
    chk("t4_master_read", rdw[0], 8'h66);

    // Partial word: frame_err, rx_data unchanged.
    send_w = '{8'hF0};
    push_w = '{8'hA1};
    run_frame(SpiMode0, 5, 6, 1, -1);
    chk("t5_rx_unchanged", bus.rx_data, 8'h99);

    // Reset mid-word, then a clean frame.
    send_w = '{8'hC3};
    push_w.delete();
    run_frame(SpiMode0, 8, 6, 0, 3);
    bus.ss   = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rst_miso", bus.miso, 1);
    chk("t6_rst_underrun", bus.tx_underrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_w = '{8'h5A};
    push_w = '{8'hB4};
    run_frame(SpiMode0, 8, 6, 1, -1);
    chk("t6_rx_data", bus.rx_data, 8'h5A);
    chk("t6_master_read", rdw[0], 8'hB4);

    // Randomised frames.
    for (int it = 0; it < 24; it++) begin
      m  = spi_mode_t'($urandom_range(0, 3));
      nw = $urandom_range(1, 3);
      nb = nw * DW + (($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : 0);
      send_w.delete();
      push_w.delete();
      for (int j = 0; j <= nw; j++) send_w.push_back(8'($urandom));
      loads = 1 + nw - ((m[0] && (nb % DW == 0)) ? 1 : 0);
      av = $urandom_range(0, loads);
      for (int j = 0; j < av; j++) push_w.push_back(8'($urandom));
      run_frame(m, nb, $urandom_range(5, 10), av, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
